// File: rtl/register_bank_sb_if.sv
// Purpose: bundles the decode/writeback-facing signals of register_bank_sb.
// Ports (signals):
//   clear, w_en, w_reg, w_data              clear request and writeback write port
//   r_reg1, r_reg2, read_data1, read_data2  two combinational read ports
//   issue_en, issue_reg, busy1, busy2       scoreboard issue mark and hazard flags
//   ready                                   1 while the bank is in RUN
// Modports: master (decode/writeback side, drives requests), slave (the bank).
interface register_bank_sb_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADD_WIDTH = 5
);
    logic                 clear;
    logic                 w_en;
    logic [ADD_WIDTH-1:0] w_reg;
    logic [WIDTH-1:0]     w_data;
    logic [ADD_WIDTH-1:0] r_reg1;
    logic [ADD_WIDTH-1:0] r_reg2;
    logic [WIDTH-1:0]     read_data1;
    logic [WIDTH-1:0]     read_data2;
    logic                 issue_en;
    logic [ADD_WIDTH-1:0] issue_reg;
    logic                 busy1;
    logic                 busy2;
    logic                 ready;

    modport master (
        output clear, w_en, w_reg, w_data, r_reg1, r_reg2, issue_en, issue_reg,
        input  read_data1, read_data2, busy1, busy2, ready
    );

    modport slave (
        input  clear, w_en, w_reg, w_data, r_reg1, r_reg2, issue_en, issue_reg,
        output read_data1, read_data2, busy1, busy2, ready
    );
endinterface

// File: rtl/register_bank_sb.sv
// Purpose: register file for the pipelined CPU with two combinational read
// ports, one synchronous write port, same-cycle write-to-read bypass, a
// per-register pending scoreboard, and a sequential clear sweep that zeroes
// registers 1..DEPTH-1 after reset or on request. Register 0 reads as zero.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (restarts the clear sweep)
//   bus  register_bank_sb_if slave modport (see interface for signal list)
module register_bank_sb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADD_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    register_bank_sb_if.slave bus
);
    localparam int unsigned          IW      = $clog2(DEPTH);
    localparam logic [ADD_WIDTH:0]   DEPTH_W = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH-1:0] FIRST   = ADD_WIDTH'(1);
    localparam logic [ADD_WIDTH-1:0] LAST    = ADD_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state;
    logic                 ready_q;
    logic [ADD_WIDTH-1:0] clr_ptr;
    logic [DEPTH-1:0]     pending;
    logic [DEPTH-1:0]     pending_next;
    logic [WIDTH-1:0]     regs [DEPTH];

    logic          run;
    logic          w_valid, iss_valid, r1_valid, r2_valid;
    logic          w_hit1, w_hit2;
    logic [IW-1:0] w_idx, iss_idx, r1_idx, r2_idx, clr_idx;

    assign run       = (state == RUN);
    assign w_valid   = bus.w_en && (bus.w_reg != '0) && ({1'b0, bus.w_reg} < DEPTH_W);
    assign iss_valid = bus.issue_en && (bus.issue_reg != '0) && ({1'b0, bus.issue_reg} < DEPTH_W);
    assign r1_valid  = (bus.r_reg1 != '0) && ({1'b0, bus.r_reg1} < DEPTH_W);
    assign r2_valid  = (bus.r_reg2 != '0) && ({1'b0, bus.r_reg2} < DEPTH_W);
    assign w_hit1    = bus.w_en && (bus.w_reg == bus.r_reg1);
    assign w_hit2    = bus.w_en && (bus.w_reg == bus.r_reg2);

    // Indices are only used after the matching range check has passed.
    assign w_idx   = bus.w_reg[IW-1:0];
    assign iss_idx = bus.issue_reg[IW-1:0];
    assign r1_idx  = bus.r_reg1[IW-1:0];
    assign r2_idx  = bus.r_reg2[IW-1:0];
    assign clr_idx = clr_ptr[IW-1:0];

    // Release first, then set: a newer producer issued in the same cycle wins.
    always_comb begin
        pending_next = pending;
        if (w_valid) pending_next[w_idx] = 1'b0;
        if (iss_valid) pending_next[iss_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            clr_ptr <= FIRST;
            pending <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + FIRST;
                    end
                end
                RUN: begin
                    if (bus.clear) begin
                        state   <= CLEAR;
                        ready_q <= 1'b0;
                        clr_ptr <= FIRST;
                        pending <= '0;
                    end else begin
                        pending <= pending_next;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                    clr_ptr <= FIRST;
                    pending <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it. Entry 0 is never written
    // because every read of index 0 is forced to zero.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[clr_idx] <= '0;
        end else if (w_valid && !bus.clear) begin
            regs[w_idx] <= bus.w_data;
        end
    end

    always_comb begin
        bus.read_data1 = '0;
        bus.read_data2 = '0;
        if (run && r1_valid) bus.read_data1 = w_hit1 ? bus.w_data : regs[r1_idx];
        if (run && r2_valid) bus.read_data2 = w_hit2 ? bus.w_data : regs[r2_idx];
    end

    assign bus.busy1 = run && r1_valid && pending[r1_idx] && !w_hit1;
    assign bus.busy2 = run && r2_valid && pending[r2_idx] && !w_hit2;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb (WIDTH=8, DEPTH=16, ADD_WIDTH=5): directed
// scenarios followed by randomized traffic checked against an array model.
module tb_register_bank_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    register_bank_sb_if #(.WIDTH(8), .ADD_WIDTH(5)) bus ();

    register_bank_sb #(.WIDTH(8), .DEPTH(16), .ADD_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, pending flags, RUN flag, sweep position.
    logic [7:0] m_regs [16];
    bit   [15:0] m_pend;
    bit          m_run;
    int          m_ptr;

    function automatic bit in_bank(logic [4:0] r);
        return (r != 0) && (r < 16);
    endfunction

    function automatic logic [7:0] exp_rd(logic [4:0] r);
        if (!m_run || !in_bank(r)) return 8'h00;
        if (bus.w_en && bus.w_reg == r) return bus.w_data;
        return m_regs[r[3:0]];
    endfunction

    function automatic bit exp_busy(logic [4:0] r);
        if (!m_run || !in_bank(r)) return 1'b0;
        return m_pend[r[3:0]] && !(bus.w_en && bus.w_reg == r);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_ptr  = 1;
        m_pend = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            m_regs[m_ptr] = 8'h00;
            if (m_ptr == 15) m_run = 1'b1;
            else m_ptr++;
        end else if (bus.clear) begin
            model_reset();
        end else begin
            if (bus.w_en && in_bank(bus.w_reg)) begin
                m_regs[bus.w_reg[3:0]] = bus.w_data;
                m_pend[bus.w_reg[3:0]] = 1'b0;
            end
            if (bus.issue_en && in_bank(bus.issue_reg)) m_pend[bus.issue_reg[3:0]] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.clear = 0; bus.w_en = 0; bus.w_reg = 0; bus.w_data = 0;
        bus.r_reg1 = 0; bus.r_reg2 = 0; bus.issue_en = 0; bus.issue_reg = 0;
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        bus.r_reg1 = 5'd3;
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.read_data1 !== 8'h00) begin n_fail++; $display("FAIL rst_read: got %h expected 00", bus.read_data1); end
        step(); step();
        rst = 1'b0;
        cnt = 0;
        while (!bus.ready && cnt < 40) begin step(); cnt++; end
        n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL rst_sweep_len: got %0d edges expected 15", cnt); end
        // Mid-run reset with live data and a pending producer.
        bus.w_en = 1; bus.w_reg = 5'd4; bus.w_data = 8'h44; bus.issue_en = 1; bus.issue_reg = 5'd4;
        step();
        idle();
        bus.r_reg1 = 5'd4; bus.r_reg2 = 5'd4;
        #1;
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy: got %b expected 1", bus.busy1); end
        n_checks++; if (bus.read_data2 !== 8'h44) begin n_fail++; $display("FAIL pre_rst_read: got %h expected 44", bus.read_data2); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy1); end
        n_checks++; if (bus.read_data1 !== 8'h00) begin n_fail++; $display("FAIL midrst_read: got %h expected 00", bus.read_data1); end
        step(); step();
        rst = 1'b0;
        cnt = 0;
        while (!bus.ready && cnt < 40) begin step(); cnt++; end
        n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL midrst_sweep_len: got %0d edges expected 15", cnt); end
        for (int i = 1; i < 16; i++) begin
            bus.r_reg1 = 5'(i); bus.r_reg2 = 5'(16 - i);
            #1;
            n_checks++; if (bus.read_data1 !== 8'h00 || bus.busy2 !== 1'b0) begin
                n_fail++; $display("FAIL post_rst_reg%0d: data=%h busy=%b expected 00/0", i, bus.read_data1, bus.busy2);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.w_en = 1; bus.w_reg = 5'd3; bus.w_data = 8'hA5; bus.r_reg1 = 5'd3;
        #1;
        n_checks++; if (bus.read_data1 !== 8'hA5) begin n_fail++; $display("FAIL wr_bypass: got %h expected a5", bus.read_data1); end
        step();
        bus.w_en = 0;
        #1;
        n_checks++; if (bus.read_data1 !== 8'hA5) begin n_fail++; $display("FAIL wr_stored: got %h expected a5", bus.read_data1); end
        bus.w_en = 1; bus.w_reg = 5'd0; bus.w_data = 8'hFF; bus.r_reg1 = 5'd0;
        #1;
        n_checks++; if (bus.read_data1 !== 8'h00) begin n_fail++; $display("FAIL wr_reg0_bypass: got %h expected 00", bus.read_data1); end
        step();
        bus.w_reg = 5'd20; bus.w_data = 8'h77; bus.r_reg1 = 5'd20; bus.r_reg2 = 5'd4;
        #1;
        n_checks++; if (bus.read_data1 !== 8'h00) begin n_fail++; $display("FAIL wr_oor_bypass: got %h expected 00", bus.read_data1); end
        step();
        bus.w_en = 0; bus.r_reg1 = 5'd0;
        #1;
        n_checks++; if (bus.read_data1 !== 8'h00) begin n_fail++; $display("FAIL wr_reg0_stored: got %h expected 00", bus.read_data1); end
        n_checks++; if (bus.read_data2 !== 8'h00) begin n_fail++; $display("FAIL wr_oor_alias: got %h expected 00", bus.read_data2); end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.issue_en = 1; bus.issue_reg = 5'd5;
        step();
        idle();
        bus.r_reg1 = 5'd5;
        #1;
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %b expected 1", bus.busy1); end
        bus.w_en = 1; bus.w_reg = 5'd5; bus.w_data = 8'h3C;
        #1;
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_bypass: got %b expected 0", bus.busy1); end
        n_checks++; if (bus.read_data1 !== 8'h3C) begin n_fail++; $display("FAIL sb_read_bypass: got %h expected 3c", bus.read_data1); end
        step();
        bus.w_en = 0;
        #1;
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_released: got %b expected 0", bus.busy1); end
        n_checks++; if (bus.read_data1 !== 8'h3C) begin n_fail++; $display("FAIL sb_read_stored: got %h expected 3c", bus.read_data1); end
    endtask

    task automatic test_simultaneous();
        idle();
        bus.issue_en = 1; bus.issue_reg = 5'd7; bus.w_en = 1; bus.w_reg = 5'd7; bus.w_data = 8'h5A;
        step();
        idle();
        bus.r_reg1 = 5'd7;
        #1;
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sim_set_wins: got %b expected 1", bus.busy1); end
        n_checks++; if (bus.read_data1 !== 8'h5A) begin n_fail++; $display("FAIL sim_data: got %h expected 5a", bus.read_data1); end
    endtask

    task automatic test_clear_request();
        int cnt;
        idle();
        for (int i = 1; i < 16; i++) begin
            bus.w_en = 1; bus.w_reg = 5'(i); bus.w_data = 8'(8'h10 + i);
            bus.issue_en = (i == 15); bus.issue_reg = 5'd6;
            step();
        end
        idle();
        bus.r_reg1 = 5'd2; bus.r_reg2 = 5'd6;
        #1;
        n_checks++; if (bus.read_data1 !== 8'h12 || bus.busy2 !== 1'b1) begin
            n_fail++; $display("FAIL clr_preload: data=%h busy=%b expected 12/1", bus.read_data1, bus.busy2);
        end
        bus.clear = 1; bus.w_en = 1; bus.w_reg = 5'd2; bus.w_data = 8'hEE;
        step();
        bus.clear = 0; bus.issue_en = 1; bus.issue_reg = 5'd6;
        #1;
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_low: got %b expected 0", bus.ready); end
        n_checks++; if (bus.read_data1 !== 8'h00 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL clr_outputs: data=%h busy=%b expected 00/0", bus.read_data1, bus.busy2);
        end
        cnt = 0;
        while (!bus.ready && cnt < 40) begin step(); cnt++; end
        n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL clr_sweep_len: got %0d edges expected 15", cnt); end
        idle();
        for (int i = 1; i < 16; i++) begin
            bus.r_reg1 = 5'(i); bus.r_reg2 = 5'(i);
            #1;
            n_checks++; if (bus.read_data1 !== 8'h00 || bus.read_data2 !== 8'h00 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
                n_fail++; $display("FAIL clr_reg%0d: data=%h/%h busy=%b/%b expected 00/00 0/0",
                                   i, bus.read_data1, bus.read_data2, bus.busy1, bus.busy2);
            end
        end
    endtask

    task automatic test_dual_port();
        idle();
        bus.w_en = 1; bus.w_reg = 5'd9; bus.w_data = 8'hC3; bus.r_reg1 = 5'd9; bus.r_reg2 = 5'd9;
        #1;
        n_checks++; if (bus.read_data1 !== 8'hC3 || bus.read_data2 !== 8'hC3) begin
            n_fail++; $display("FAIL dual_bypass: got %h/%h expected c3/c3", bus.read_data1, bus.read_data2);
        end
        step();
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            bus.clear     = ($urandom_range(0, 59) == 0);
            bus.w_en      = 1'($urandom_range(0, 1));
            bus.w_reg     = 5'($urandom_range(0, 19));
            bus.w_data    = 8'($urandom);
            bus.issue_en  = 1'($urandom_range(0, 1));
            bus.issue_reg = 5'($urandom_range(0, 19));
            bus.r_reg1    = ($urandom_range(0, 3) == 0) ? bus.w_reg : 5'($urandom_range(0, 19));
            bus.r_reg2    = ($urandom_range(0, 3) == 0) ? bus.issue_reg : 5'($urandom_range(0, 19));
            #1;
            n_checks++; if (bus.ready !== m_run) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, bus.ready, m_run); end
            n_checks++; if (bus.read_data1 !== exp_rd(bus.r_reg1)) begin
                n_fail++; $display("FAIL rnd_rd1[%0d]: r=%0d got %h expected %h", n, bus.r_reg1, bus.read_data1, exp_rd(bus.r_reg1));
            end
            n_checks++; if (bus.read_data2 !== exp_rd(bus.r_reg2)) begin
                n_fail++; $display("FAIL rnd_rd2[%0d]: r=%0d got %h expected %h", n, bus.r_reg2, bus.read_data2, exp_rd(bus.r_reg2));
            end
            n_checks++; if (bus.busy1 !== exp_busy(bus.r_reg1)) begin
                n_fail++; $display("FAIL rnd_busy1[%0d]: r=%0d got %b expected %b", n, bus.r_reg1, bus.busy1, exp_busy(bus.r_reg1));
            end
            n_checks++; if (bus.busy2 !== exp_busy(bus.r_reg2)) begin
                n_fail++; $display("FAIL rnd_busy2[%0d]: r=%0d got %b expected %b", n, bus.r_reg2, bus.busy2, exp_busy(bus.r_reg2));
            end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_simultaneous();
        test_clear_request();
        test_dual_port();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
